sw_fifo_base_reader: RTL and testbench

//   Read side of the 18-bit sequence FIFO. Pops packed words from a standard (non-FWFT) FIFO, decodes HEAD/DATA

---
 rtl/sw_seq_pkg.sv | 30 +++
 rtl/sw_fifo_prefetch.sv | 43 ++++
 rtl/sw_fifo_base_reader.sv | 111 +++++++++++
 tb/tb_sw_fifo_base_reader.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sw_seq_pkg.sv
// Shared constants and types for the Smith-Waterman sequence FIFO word format.
package sw_seq_pkg;

  localparam int unsigned DATA_W = 18;
  localparam int unsigned PAY_W  = 16;
  localparam int unsigned BASE_W = 2;
  localparam int unsigned BPW    = PAY_W / BASE_W;
  localparam int unsigned LEN_W  = 16;
  localparam int unsigned CNT_W  = $clog2(BPW + 1);

  localparam logic [1:0] TAG_DATA = 2'b00;
  localparam logic [1:0] TAG_HEAD = 2'b01;

  typedef enum logic [1:0] {
    BASE_A = 2'd0,
    BASE_C = 2'd1,
    BASE_G = 2'd2,
    BASE_T = 2'd3
  } base_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEQ  = 1'b1
  } state_e;

  function automatic logic [1:0] word_tag(input logic [DATA_W-1:0] w);
    return w[DATA_W-1 -: 2];
  endfunction

endpackage

// File: rtl/sw_fifo_prefetch.sv
// One-word prefetch in front of a standard (non-FWFT) FIFO: at most one read in flight or one word held.
module sw_fifo_prefetch #(
  parameter int unsigned W = 18
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_empty,
  input  logic [W-1:0] i_dout,
  input  logic         i_pop,
  output logic         o_rd_en,
  output logic         o_hold_valid,
  output logic [W-1:0] o_hold
);

  logic         r_rd_pend;
  logic         r_hold_valid;
  logic [W-1:0] r_hold;
  logic         w_rd_en;

  // Reset also masks the pop request so nothing leaves the FIFO while held in reset.
  assign w_rd_en = !rst && !i_empty && !r_rd_pend && !r_hold_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_pend    <= 1'b0;
      r_hold_valid <= 1'b0;
      r_hold       <= '0;
    end else begin
      r_rd_pend <= w_rd_en;
      if (r_rd_pend) begin
        r_hold       <= i_dout;
        r_hold_valid <= 1'b1;
      end else if (i_pop) begin
        r_hold_valid <= 1'b0;
      end
    end
  end

  assign o_rd_en      = w_rd_en;
  assign o_hold_valid = r_hold_valid;
  assign o_hold       = r_hold;

endmodule

// File: rtl/sw_fifo_base_reader.sv
// Decodes HEAD/DATA words from the sequence FIFO and streams 2-bit bases over valid/ready.
module sw_fifo_base_reader
  import sw_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] fifo_dout,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  output logic [BASE_W-1:0] base_out,
  output logic              base_valid,
  input  logic              base_ready,
  output logic              base_first,
  output logic              base_last,
  output logic [LEN_W-1:0]  seq_len,
  output logic              err_tag
);

  state_e            r_state;
  logic [PAY_W-1:0]  r_shreg;
  logic [CNT_W-1:0]  r_cnt;
  logic [LEN_W-1:0]  r_remaining;
  logic [LEN_W-1:0]  r_seq_len;
  logic              r_first_pend;
  logic              r_err;

  logic              w_hold_valid;
  logic [DATA_W-1:0] w_hold;
  logic [1:0]        w_tag;
  logic [LEN_W-1:0]  w_len;
  logic              w_xfer;
  logic              w_done;
  logic              w_idle_dec;
  logic              w_load_ok;
  logic              w_pop;

  sw_fifo_prefetch #(.W(DATA_W)) u_prefetch (
    .clk          (clk),
    .rst          (rst),
    .i_empty      (fifo_empty),
    .i_dout       (fifo_dout),
    .i_pop        (w_pop),
    .o_rd_en      (fifo_rd_en),
    .o_hold_valid (w_hold_valid),
    .o_hold       (w_hold)
  );

  assign w_tag      = word_tag(w_hold);
  assign w_len      = LEN_W'(w_hold[PAY_W-1:0]);
  assign w_xfer     = base_valid && base_ready;
  assign w_done     = w_xfer && (r_remaining == LEN_W'(1));
  // A sequence finishing this cycle lets the held word be decoded as if already idle.
  assign w_idle_dec = (r_state == ST_IDLE) || w_done;
  assign w_load_ok  = (r_cnt == '0) || (w_xfer && (r_cnt == CNT_W'(1)));
  assign w_pop      = w_hold_valid && (w_idle_dec || (w_tag != TAG_DATA) || w_load_ok);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_shreg      <= '0;
      r_cnt        <= '0;
      r_remaining  <= '0;
      r_seq_len    <= '0;
      r_first_pend <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (w_xfer) begin
        r_shreg      <= r_shreg >> BASE_W;
        r_cnt        <= r_cnt - CNT_W'(1);
        r_remaining  <= r_remaining - LEN_W'(1);
        r_first_pend <= 1'b0;
        if (w_done) begin
          r_cnt   <= '0;
          r_state <= ST_IDLE;
        end
      end
      if (w_hold_valid) begin
        if (w_tag == TAG_HEAD) begin
          // HEAD inside a live sequence aborts it, then starts afresh.
          if (!w_idle_dec) begin
            r_err <= 1'b1;
            r_cnt <= '0;
          end
          r_seq_len   <= w_len;
          r_remaining <= w_len;
          if (w_len != '0) begin
            r_first_pend <= 1'b1;
            r_state      <= ST_SEQ;
          end else begin
            r_first_pend <= 1'b0;
            r_state      <= ST_IDLE;
          end
        end else if (w_idle_dec || (w_tag != TAG_DATA)) begin
          r_err <= 1'b1;
        end else if (w_load_ok) begin
          r_shreg <= w_hold[PAY_W-1:0];
          r_cnt   <= CNT_W'(BPW);
        end
      end
    end
  end

  assign base_valid = (r_cnt != '0);
  assign base_out   = r_shreg[BASE_W-1:0];
  assign base_first = r_first_pend;
  assign base_last  = (r_remaining == LEN_W'(1));
  assign seq_len    = r_seq_len;
  assign err_tag    = r_err;

endmodule

// File: tb/tb_sw_fifo_base_reader.sv
// Directed bench for sw_fifo_base_reader with a FIFO model and a word-stream reference model.
module tb_sw_fifo_base_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [17:0] fifo_dout = '0;
  logic        fifo_empty = 1'b1;
  logic        fifo_rd_en;
  logic [1:0]  base_out;
  logic        base_valid;
  logic        base_ready = 1'b1;
  logic        base_first;
  logic        base_last;
  logic [15:0] seq_len;
  logic        err_tag;

  sw_fifo_base_reader dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_dout  (fifo_dout),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .base_out   (base_out),
    .base_valid (base_valid),
    .base_ready (base_ready),
    .base_first (base_first),
    .base_last  (base_last),
    .seq_len    (seq_len),
    .err_tag    (err_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] b;
    logic       f;
    logic       l;
    bit         ab;
    int         sid;
  } exp_t;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          err_seen = 0;
  logic [17:0] fq[$];
  exp_t        expq[$];
  logic [1:0]  obs_b[$];
  logic        obs_f[$];
  logic        obs_l[$];
  int          obs_c[$];

  // reference model state: parses the pushed word stream
  bit m_in_seq = 0;
  int m_rem = 0;
  bit m_first = 0;
  int m_sid = 0;
  int m_err_exp = 0;

  always @(posedge clk) cyc++;

  // standard FIFO: data appears the cycle after a pop, empty flag registered
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      checks++;
      if (fq.size() == 0) begin
        failures++;
        $display("FAIL pop_while_empty cyc=%0d", cyc);
      end else begin
        fifo_dout <= fq.pop_front();
      end
    end
    fifo_empty <= (fq.size() == 0);
  end

  task automatic push_word(input logic [17:0] w);
    exp_t e;
    fq.push_back(w);
    case (w[17:16])
      2'b01: begin
        if (m_in_seq) begin
          m_err_exp++;
          foreach (expq[i]) if (expq[i].sid == m_sid) expq[i].ab = 1'b1;
        end
        m_sid++;
        m_rem    = int'(w[15:0]);
        m_in_seq = (m_rem > 0);
        m_first  = 1'b1;
      end
      2'b00: begin
        if (!m_in_seq) m_err_exp++;
        else begin
          for (int k = 0; k < 8; k++) begin
            if (m_rem > 0) begin
              e.b   = w[2*k +: 2];
              e.f   = m_first;
              e.l   = (m_rem == 1);
              e.ab  = 1'b0;
              e.sid = m_sid;
              expq.push_back(e);
              m_first = 1'b0;
              m_rem--;
            end
          end
          if (m_rem == 0) m_in_seq = 1'b0;
        end
      end
      default: m_err_exp++;
    endcase
  endtask

  function automatic int live_exp();
    int n = 0;
    foreach (expq[i]) if (!expq[i].ab) n++;
    return n;
  endfunction

  // single compare process: every transfer, every stall, every error pulse
  bit         prev_stall = 0;
  bit         prev_err = 0;
  logic [1:0] prev_b;
  logic       prev_f, prev_l;
  exp_t       ce;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 0;
      prev_err   = 0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (!(base_valid && base_out == prev_b && base_first == prev_f && base_last == prev_l)) begin
          failures++;
          $display("FAIL stall_hold cyc=%0d got v=%0b b=%0d f=%0b l=%0b want v=1 b=%0d f=%0b l=%0b",
                   cyc, base_valid, base_out, base_first, base_last, prev_b, prev_f, prev_l);
        end
      end
      if (base_valid && base_ready) begin
        obs_b.push_back(base_out);
        obs_f.push_back(base_first);
        obs_l.push_back(base_last);
        obs_c.push_back(cyc);
        while (base_first && expq.size() > 0 && expq[0].ab && !expq[0].f) void'(expq.pop_front());
        checks++;
        if (expq.size() == 0) begin
          failures++;
          $display("FAIL xfer_unexpected cyc=%0d got b=%0d f=%0b l=%0b want none", cyc, base_out, base_first, base_last);
        end else begin
          ce = expq.pop_front();
          if (base_out != ce.b || base_first != ce.f || base_last != ce.l) begin
            failures++;
            $display("FAIL xfer_data cyc=%0d got b=%0d f=%0b l=%0b want b=%0d f=%0b l=%0b",
                     cyc, base_out, base_first, base_last, ce.b, ce.f, ce.l);
          end
        end
      end
      if (err_tag) begin
        err_seen++;
        checks++;
        if (prev_err) begin
          failures++;
          $display("FAIL err_width cyc=%0d got 2+ cycles want 1", cyc);
        end
      end
      prev_err   = err_tag;
      prev_stall = base_valid && !base_ready;
      prev_b     = base_out;
      prev_f     = base_first;
      prev_l     = base_last;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((live_exp() > 0 || fq.size() > 0 || base_valid) && n < 2000) begin
      tick();
      n++;
    end
    repeat (8) tick();
    check({name, "_timeout"}, int'(n >= 2000), 0);
    for (int i = expq.size() - 1; i >= 0; i--) if (expq[i].ab) expq.delete(i);
    check({name, "_err_count"}, err_seen, m_err_exp);
    check({name, "_left"}, expq.size(), 0);
  endtask

  initial begin
    int s;
    int e0;
    int bad;

    // reset held with data waiting: nothing may be popped
    tick();
    push_word({2'b01, 16'd5});
    push_word({2'b00, 16'h00E4});
    for (int i = 0; i < 10; i++) begin
      tick();
      bad = int'(fifo_rd_en || base_valid || base_first || base_last || err_tag || (seq_len != 16'd0));
      check("reset_outputs", bad, 0);
    end
    check("reset_no_pop", fq.size(), 2);
    rst = 1'b0;

    // len=5, payload 00E4 -> 0,1,2,3,0
    s = obs_b.size();
    drain("len5");
    check("len5_count", obs_b.size() - s, 5);
    if (obs_b.size() - s == 5) begin
      check("len5_b0", int'(obs_b[s]), 0);
      check("len5_b1", int'(obs_b[s+1]), 1);
      check("len5_b2", int'(obs_b[s+2]), 2);
      check("len5_b3", int'(obs_b[s+3]), 3);
      check("len5_b4", int'(obs_b[s+4]), 0);
      check("len5_first", int'({obs_f[s], obs_f[s+4]}), 2);
      check("len5_last", int'({obs_l[s+3], obs_l[s+4]}), 1);
    end
    check("len5_seq_len", int'(seq_len), 5);

    // len=16 prefilled: 16 consecutive transfers across the word boundary
    s = obs_b.size();
    push_word({2'b01, 16'd16});
    push_word({2'b00, 16'h4E4E});
    push_word({2'b00, 16'h0003});
    drain("len16");
    check("len16_count", obs_b.size() - s, 16);
    if (obs_b.size() - s == 16) begin
      check("len16_span", obs_c[s+15] - obs_c[s], 15);
      check("len16_b0", int'(obs_b[s]), 2);
      check("len16_b8", int'(obs_b[s+8]), 3);
    end

    // len=20 with random backpressure
    s = obs_b.size();
    e0 = err_seen;
    push_word({2'b01, 16'd20});
    push_word({2'b00, 16'h1234});
    push_word({2'b00, 16'h5678});
    push_word({2'b00, 16'h9ABC});
    for (int n = 0; n < 3000 && (live_exp() > 0 || fq.size() > 0 || base_valid); n++) begin
      tick();
      base_ready = 1'($urandom_range(0, 1));
    end
    base_ready = 1'b1;
    drain("len20");
    check("len20_count", obs_b.size() - s, 20);
    if (obs_b.size() - s == 20) begin
      check("len20_b0", int'(obs_b[s]), 0);
      check("len20_b19", int'(obs_b[s+19]), 2);
      check("len20_last", int'(obs_l[s+19]), 1);
    end
    check("len20_no_err", err_seen - e0, 0);

    // orphan DATA and reserved tag, then a valid short sequence
    s = obs_b.size();
    e0 = err_seen;
    push_word({2'b00, 16'hFFFF});
    push_word({2'b11, 16'h1234});
    push_word({2'b01, 16'd2});
    push_word({2'b00, 16'h0009});
    drain("errs");
    check("errs_pulses", err_seen - e0, 2);
    check("errs_count", obs_b.size() - s, 2);
    if (obs_b.size() - s == 2) begin
      check("errs_b0", int'(obs_b[s]), 1);
      check("errs_b1", int'(obs_b[s+1]), 2);
    end

    // HEAD inside a live sequence aborts it
    e0 = err_seen;
    push_word({2'b01, 16'd10});
    push_word({2'b00, 16'h0000});
    push_word({2'b01, 16'd3});
    push_word({2'b00, 16'h001B});
    s = obs_b.size();
    drain("abort");
    check("abort_pulse", err_seen - e0, 1);
    check("abort_seq_len", int'(seq_len), 3);
    check("abort_min", int'(obs_b.size() - s >= 3), 1);
    if (obs_b.size() - s >= 3) begin
      s = obs_b.size() - 3;
      check("abort_b0", int'(obs_b[s]), 3);
      check("abort_b1", int'(obs_b[s+1]), 2);
      check("abort_b2", int'(obs_b[s+2]), 1);
      check("abort_flags", int'({obs_f[s], obs_l[s], obs_f[s+2], obs_l[s+2]}), 4'b1001);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
